cern_be_arbiter: RTL and testbench

- Shares one CERN-BE style slave bus between two requesters, for example a host-side bridge and an internal scrubber or sequencer.
- Round-robin arbitration at transaction granularity.
- A watchdog terminates transactions the slave never acknowledges, returning an error flag.
- Sits between the bus-bridge decoders and a single CERN-BE submap interface.

---
 rtl/cern_be_arb_pkg.sv | 15 +
 rtl/cern_be_rr_arb2.sv | 19 +
 rtl/cern_be_arbiter.sv | 141 ++++++++++++++
 tb/tb_cern_be_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cern_be_arb_pkg.sv
// Shared types and constants for the two-requester CERN-BE bus arbiter.
package cern_be_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/cern_be_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the requester that was
// not granted last time wins.
module cern_be_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/cern_be_arbiter.sv
// Shares one CERN-BE slave bus between two requesters with transaction-level
// round-robin arbitration and a watchdog that errors out unacknowledged accesses.
module cern_be_arbiter
    import cern_be_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic              m0_rd_mem,
    input  logic              m0_wr_mem,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_rd_done,
    output logic              m0_wr_done,
    output logic              m0_err,

    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    input  logic              m1_rd_mem,
    input  logic              m1_wr_mem,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_rd_done,
    output logic              m1_wr_done,
    output logic              m1_err,

    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wr_data,
    output logic              s_rd_mem,
    output logic              s_wr_mem,
    input  logic [DATA_W-1:0] s_rd_data,
    input  logic              s_rd_done,
    input  logic              s_wr_done
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t              state;
    state_t              state_d;
    logic                last_grant;
    logic                owner;
    logic                dir;
    logic [CNT_W-1:0]    wd_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic [1:0]          req;
    logic                grant;
    logic                grant_wr;
    logic                done_match;
    logic                wd_expire;
    logic                resp;

    assign req = {m1_rd_mem | m1_wr_mem, m0_rd_mem | m0_wr_mem};

    cern_be_rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // A requester asserting both strobes gets its write served first.
    assign grant_wr   = grant ? m1_wr_mem : m0_wr_mem;
    assign done_match = (dir == DIR_RD) ? s_rd_done : s_wr_done;
    assign wd_expire  = (TIMEOUT != 0) && (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (|req) state_d = BUSY;
            BUSY:    if (done_match || wd_expire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            dir        <= DIR_RD;
            wd_cnt     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner      <= grant;
                        last_grant <= grant;
                        dir        <= grant_wr ? DIR_WR : DIR_RD;
                        addr_q     <= grant ? m1_addr : m0_addr;
                        wdata_q    <= grant ? m1_wr_data : m0_wr_data;
                        wd_cnt     <= '0;
                    end
                end
                BUSY: begin
                    // A real acknowledge beats a simultaneous watchdog expiry.
                    if (done_match) begin
                        rdata_q <= (dir == DIR_RD) ? s_rd_data : '0;
                        err_q   <= 1'b0;
                    end else if (wd_expire) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp      = (state == RESP);
    assign s_rd_mem  = (state == BUSY) && (dir == DIR_RD);
    assign s_wr_mem  = (state == BUSY) && (dir == DIR_WR);
    assign s_addr    = addr_q;
    assign s_wr_data = wdata_q;

    assign m0_rd_done = resp && !owner && (dir == DIR_RD);
    assign m0_wr_done = resp && !owner && (dir == DIR_WR);
    assign m0_err     = resp && !owner && err_q;
    assign m0_rd_data = (resp && !owner) ? rdata_q : '0;

    assign m1_rd_done = resp && owner && (dir == DIR_RD);
    assign m1_wr_done = resp && owner && (dir == DIR_WR);
    assign m1_err     = resp && owner && err_q;
    assign m1_rd_data = (resp && owner) ? rdata_q : '0;

endmodule

// File: tb/tb_cern_be_arbiter.sv
// Directed bench for cern_be_arbiter: single read, contention and fairness,
// watchdog timeout, done/timeout tie, wrong-direction ack and reset mid-transaction.
module tb_cern_be_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    localparam logic [31:0] WD_A = 32'hA0A0_0001;
    localparam logic [31:0] WD_B = 32'hB1B1_0002;
    localparam logic [31:0] WD_C = 32'h0C0C_0C0C;

    logic              aclk = 1'b0;
    logic              areset;
    logic [ADDR_W-1:0] m0_addr, m1_addr, s_addr;
    logic [DATA_W-1:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data;
    logic [DATA_W-1:0] s_wr_data, s_rd_data;
    logic              m0_rd_mem, m0_wr_mem, m0_rd_done, m0_wr_done, m0_err;
    logic              m1_rd_mem, m1_wr_mem, m1_rd_done, m1_wr_done, m1_err;
    logic              s_rd_mem, s_wr_mem, s_rd_done, s_wr_done;

    int checks = 0;
    int errors = 0;
    int n;

    cern_be_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .m0_addr    (m0_addr),
        .m0_wr_data (m0_wr_data),
        .m0_rd_mem  (m0_rd_mem),
        .m0_wr_mem  (m0_wr_mem),
        .m0_rd_data (m0_rd_data),
        .m0_rd_done (m0_rd_done),
        .m0_wr_done (m0_wr_done),
        .m0_err     (m0_err),
        .m1_addr    (m1_addr),
        .m1_wr_data (m1_wr_data),
        .m1_rd_mem  (m1_rd_mem),
        .m1_wr_mem  (m1_wr_mem),
        .m1_rd_data (m1_rd_data),
        .m1_rd_done (m1_rd_done),
        .m1_wr_done (m1_wr_done),
        .m1_err     (m1_err),
        .s_addr     (s_addr),
        .s_wr_data  (s_wr_data),
        .s_rd_mem   (s_rd_mem),
        .s_wr_mem   (s_wr_mem),
        .s_rd_data  (s_rd_data),
        .s_rd_done  (s_rd_done),
        .s_wr_done  (s_wr_done)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Slave model: acks in strobe cycle ack_at (negative = never), returns strobe length.
    task automatic run_busy(input int ack_at, input logic rd, input logic [31:0] rdata,
                            output int cycles);
        cycles = 0;
        while ((s_rd_mem || s_wr_mem) && cycles < 40) begin
            if (cycles == ack_at) begin
                if (rd) begin
                    s_rd_done = 1'b1;
                    s_rd_data = rdata;
                end else begin
                    s_wr_done = 1'b1;
                end
            end
            cycles++;
            step();
            s_rd_done = 1'b0;
            s_wr_done = 1'b0;
        end
    endtask

    task automatic m1_quiet(input string tag);
        check(tag, 32'({m1_rd_done, m1_wr_done, m1_err}), 0);
        check({tag, "_data"}, m1_rd_data, 0);
    endtask

    task automatic m0_quiet(input string tag);
        check(tag, 32'({m0_rd_done, m0_wr_done, m0_err}), 0);
        check({tag, "_data"}, m0_rd_data, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        areset = 1'b1;
        m0_addr = '0; m0_wr_data = '0; m0_rd_mem = 1'b0; m0_wr_mem = 1'b0;
        m1_addr = '0; m1_wr_data = '0; m1_rd_mem = 1'b0; m1_wr_mem = 1'b0;
        s_rd_data = '0; s_rd_done = 1'b0; s_wr_done = 1'b0;
        step();
        step();

        check("rst_strobes", 32'({s_rd_mem, s_wr_mem}), 0);
        check("rst_s_addr", 32'(s_addr), 0);
        check("rst_s_wr_data", s_wr_data, 0);
        m0_quiet("rst_m0");
        m1_quiet("rst_m1");
        areset = 1'b0;
        step();

        // Single read, slave acks two cycles after its strobe rises.
        m0_addr = 16'h0010;
        m0_rd_mem = 1'b1;
        step();
        check("rd_strobe", 32'(s_rd_mem), 1);
        check("rd_wr_strobe", 32'(s_wr_mem), 0);
        check("rd_addr", 32'(s_addr), 32'h0010);
        run_busy(2, 1'b1, 32'hCAFE_0001, n);
        check("rd_strobe_len", n, 3);
        check("rd_done", 32'(m0_rd_done), 1);
        check("rd_data", m0_rd_data, 32'hCAFE_0001);
        check("rd_err", 32'(m0_err), 0);
        check("rd_wr_done", 32'(m0_wr_done), 0);
        m1_quiet("rd_m1");
        m0_rd_mem = 1'b0;
        step();
        check("rd_done_pulse", 32'(m0_rd_done), 0);
        check("rd_idle_strobe", 32'(s_rd_mem), 0);

        // Contention straight after reset: m0 first, then m1.
        areset = 1'b1;
        step();
        areset = 1'b0;
        step();
        m0_addr = 16'h0020; m0_wr_data = WD_A; m0_wr_mem = 1'b1;
        m1_addr = 16'h0030; m1_wr_data = WD_B; m1_wr_mem = 1'b1;
        step();
        check("cont_first_wdata", s_wr_data, WD_A);
        check("cont_first_addr", 32'(s_addr), 32'h0020);
        run_busy(1, 1'b0, 32'h0, n);
        check("cont_first_len", n, 2);
        check("cont_m0_done", 32'(m0_wr_done), 1);
        m1_quiet("cont_m1_first");
        m0_wr_mem = 1'b0;
        step();
        check("cont_idle_gap", 32'(s_wr_mem), 0);
        step();
        check("cont_second_wdata", s_wr_data, WD_B);
        check("cont_second_addr", 32'(s_addr), 32'h0030);
        run_busy(1, 1'b0, 32'h0, n);
        check("cont_m1_done", 32'(m1_wr_done), 1);
        m0_quiet("cont_m0_second");

        // Both held: grants alternate 0,1,0,1.
        m0_wr_mem = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            step();
            check($sformatf("alt%0d_wdata", i), s_wr_data, (i % 2 == 0) ? WD_A : WD_B);
            run_busy(0, 1'b0, 32'h0, n);
            check($sformatf("alt%0d_done", i),
                  32'((i % 2 == 0) ? m0_wr_done : m1_wr_done), 1);
        end
        m0_wr_mem = 1'b0;
        m1_wr_mem = 1'b0;
        step();

        // Watchdog: silent slave on an m1 read.
        m1_addr = 16'h0200;
        s_rd_data = 32'hDEAD_BEEF;
        m1_rd_mem = 1'b1;
        step();
        check("to_strobe", 32'(s_rd_mem), 1);
        run_busy(-1, 1'b1, 32'hDEAD_BEEF, n);
        check("to_strobe_len", n, TIMEOUT);
        check("to_done", 32'(m1_rd_done), 1);
        check("to_err", 32'(m1_err), 1);
        check("to_data", m1_rd_data, 0);
        m0_quiet("to_m0");
        m1_rd_mem = 1'b0;
        step();
        check("to_idle_done", 32'({m1_rd_done, m1_err}), 0);
        check("to_idle_strobe", 32'(s_rd_mem), 0);

        // Ack lands in the last watchdog cycle: done wins.
        m0_addr = 16'h0040;
        m0_rd_mem = 1'b1;
        step();
        run_busy(TIMEOUT - 1, 1'b1, 32'h1234_5678, n);
        check("tie_strobe_len", n, TIMEOUT);
        check("tie_done", 32'(m0_rd_done), 1);
        check("tie_err", 32'(m0_err), 0);
        check("tie_data", m0_rd_data, 32'h1234_5678);
        m0_rd_mem = 1'b0;
        step();

        // Read ack during a write is ignored.
        m1_wr_data = WD_C;
        m1_wr_mem = 1'b1;
        step();
        s_rd_done = 1'b1;
        s_rd_data = 32'h0000_0055;
        step();
        s_rd_done = 1'b0;
        check("wdir_strobe_held", 32'(s_wr_mem), 1);
        check("wdir_no_done", 32'({m1_rd_done, m1_wr_done}), 0);
        run_busy(0, 1'b0, 32'h0, n);
        check("wdir_len", n, 1);
        check("wdir_wr_done", 32'(m1_wr_done), 1);
        check("wdir_rd_done", 32'(m1_rd_done), 0);
        check("wdir_err", 32'(m1_err), 0);
        m1_wr_mem = 1'b0;
        step();

        // Reset mid-BUSY after an m0 grant; first tie afterwards still goes to m0.
        m0_addr = 16'h0050;
        m0_wr_data = WD_A;
        m0_wr_mem = 1'b1;
        step();
        check("rstb_strobe", 32'(s_wr_mem), 1);
        #2;
        areset = 1'b1;
        #1;
        check("rstb_strobe_drop", 32'(s_wr_mem), 0);
        check("rstb_s_addr", 32'(s_addr), 0);
        check("rstb_s_wr_data", s_wr_data, 0);
        m0_wr_mem = 1'b0;
        step();
        m0_quiet("rstb_m0_in_reset");
        areset = 1'b0;
        step();
        m0_quiet("rstb_m0_after");
        step();
        check("rstb_idle_strobe", 32'(s_wr_mem), 0);
        m0_wr_data = WD_A; m0_wr_mem = 1'b1;
        m1_wr_data = WD_B; m1_wr_mem = 1'b1;
        step();
        check("rstb_tie_wdata", s_wr_data, WD_A);
        run_busy(0, 1'b0, 32'h0, n);
        check("rstb_tie_done", 32'(m0_wr_done), 1);
        m0_wr_mem = 1'b0;
        m1_wr_mem = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
